// File: rtl/mchan_trans_splitter.sv
// mchan_trans_splitter: re-issues one arbitrated MCHAN transaction as sub-transactions
// that never cross a 2**MAX_BURST_LOG-byte boundary in external address space.
// Latency 1 cycle from accept to first out_req_o; outputs held stable until out_gnt_i.
// Optional macro MCHAN_SPLIT_STATS_EN adds split_cnt_o, a saturating out-handshake count.
module mchan_trans_splitter #(
  parameter int EXT_ADD_WIDTH   = 32,
  parameter int TCDM_ADD_WIDTH  = 16,
  parameter int MCHAN_LEN_WIDTH = 16,
  parameter int MCHAN_OPC_WIDTH = 1,
  parameter int TRANS_SID_WIDTH = 1,
  parameter int TRANS_CID_WIDTH = 1,
  parameter int MAX_BURST_LOG   = 7
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_req_i,
  output logic                       in_gnt_o,
  input  logic [EXT_ADD_WIDTH-1:0]   in_ext_add_i,
  input  logic [TCDM_ADD_WIDTH-1:0]  in_tcdm_add_i,
  input  logic [MCHAN_LEN_WIDTH-1:0] in_len_i,
  input  logic [MCHAN_OPC_WIDTH-1:0] in_opc_i,
  input  logic [TRANS_SID_WIDTH-1:0] in_sid_i,
  input  logic [TRANS_CID_WIDTH-1:0] in_cid_i,
  output logic                       out_req_o,
  input  logic                       out_gnt_i,
  output logic [EXT_ADD_WIDTH-1:0]   out_ext_add_o,
  output logic [TCDM_ADD_WIDTH-1:0]  out_tcdm_add_o,
  output logic [MAX_BURST_LOG-1:0]   out_len_o,
  output logic [MCHAN_OPC_WIDTH-1:0] out_opc_o,
  output logic [TRANS_SID_WIDTH-1:0] out_sid_o,
  output logic [TRANS_CID_WIDTH-1:0] out_cid_o,
  output logic                       out_last_o,
`ifdef MCHAN_SPLIT_STATS_EN
  output logic [15:0]                split_cnt_o,
`endif
  output logic                       busy_o
);

  // Remaining byte count is one bit wider than the length field so a
  // full-range length (all ones, i.e. 2**MCHAN_LEN_WIDTH bytes) fits.
  localparam int REM_W = MCHAN_LEN_WIDTH + 1;
  localparam int CHK_W = MAX_BURST_LOG + 1;
  localparam logic [CHK_W-1:0] BURST_BYTES = CHK_W'(2 ** MAX_BURST_LOG);

  typedef enum logic {IDLE, SPLIT} state_e;

  state_e                     state_q;
  logic                       gnt_q, req_q, busy_q, last_q;
  logic [EXT_ADD_WIDTH-1:0]   ext_q;
  logic [TCDM_ADD_WIDTH-1:0]  tcdm_q;
  logic [REM_W-1:0]           rem_q;
  logic [MAX_BURST_LOG-1:0]   len_q;
  logic [MCHAN_OPC_WIDTH-1:0] opc_q;
  logic [TRANS_SID_WIDTH-1:0] sid_q;
  logic [TRANS_CID_WIDTH-1:0] cid_q;

  logic                       accept, xfer;
  logic [CHK_W-1:0]           cur_chunk, nxt_chunk, nxt_len_full;
  logic [EXT_ADD_WIDTH-1:0]   ext_d;
  logic [TCDM_ADD_WIDTH-1:0]  tcdm_d;
  logic [REM_W-1:0]           rem_d;
  logic [MAX_BURST_LOG-1:0]   len_d;
  logic                       last_d;

  // Bytes left before the next burst boundary, clipped to what remains.
  // Never zero: room is at least 1 and rem is non-zero in SPLIT.
  function automatic logic [CHK_W-1:0] chunk_of(input logic [EXT_ADD_WIDTH-1:0] ext,
                                                input logic [REM_W-1:0]         rem);
    logic [CHK_W-1:0] room;
    room = BURST_BYTES - {1'b0, ext[MAX_BURST_LOG-1:0]};
    if (rem < REM_W'(room)) chunk_of = rem[CHK_W-1:0];
    else                    chunk_of = room;
  endfunction

  // Next sub-transaction: either the first one of a new transaction or the
  // one following the sub currently being granted.
  always_comb begin
    accept    = in_req_i && gnt_q && (state_q == IDLE);
    xfer      = req_q && out_gnt_i;
    cur_chunk = {1'b0, len_q} + CHK_W'(1);
    if (accept) begin
      ext_d  = in_ext_add_i;
      tcdm_d = in_tcdm_add_i;
      rem_d  = REM_W'(in_len_i) + REM_W'(1);
    end else begin
      ext_d  = ext_q + EXT_ADD_WIDTH'(cur_chunk);
      tcdm_d = tcdm_q + TCDM_ADD_WIDTH'(cur_chunk);
      rem_d  = rem_q - REM_W'(cur_chunk);
    end
    nxt_chunk    = chunk_of(ext_d, rem_d);
    nxt_len_full = nxt_chunk - CHK_W'(1);
    len_d        = nxt_len_full[MAX_BURST_LOG-1:0];
    last_d       = (rem_d == REM_W'(nxt_chunk));
  end

  // Control FSM with registered handshake and sub-transaction outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      ext_q   <= '0;
      tcdm_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      opc_q   <= '0;
      sid_q   <= '0;
      cid_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          gnt_q <= 1'b1;
          if (accept) begin
            state_q <= SPLIT;
            gnt_q   <= 1'b0;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            ext_q   <= ext_d;
            tcdm_q  <= tcdm_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            last_q  <= last_d;
            opc_q   <= in_opc_i;
            sid_q   <= in_sid_i;
            cid_q   <= in_cid_i;
          end
        end
        SPLIT: begin
          if (xfer) begin
            if (last_q) begin
              // Return to IDLE; the grant reappears next cycle (one bubble).
              state_q <= IDLE;
              req_q   <= 1'b0;
              busy_q  <= 1'b0;
              gnt_q   <= 1'b1;
            end else begin
              ext_q  <= ext_d;
              tcdm_q <= tcdm_d;
              rem_q  <= rem_d;
              len_q  <= len_d;
              last_q <= last_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MCHAN_SPLIT_STATS_EN
  logic [15:0] cnt_q;

  // Saturating count of completed out handshakes.
  always_ff @(posedge clk_i) begin
    if (rst_i)                       cnt_q <= '0;
    else if (xfer && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign split_cnt_o = cnt_q;
`endif

  assign in_gnt_o       = gnt_q;
  assign out_req_o      = req_q;
  assign busy_o         = busy_q;
  assign out_ext_add_o  = ext_q;
  assign out_tcdm_add_o = tcdm_q;
  assign out_len_o      = len_q;
  assign out_last_o     = last_q;
  assign out_opc_o      = opc_q;
  assign out_sid_o      = sid_q;
  assign out_cid_o      = cid_q;

endmodule

// File: tb/tb_mchan_trans_splitter.sv
// Testbench for mchan_trans_splitter: directed cases plus randomized transactions
// checked against a byte-count model of the boundary-splitting rule.
module tb_mchan_trans_splitter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_req_i = 1'b0;
  logic        in_gnt_o;
  logic [31:0] in_ext_add_i = '0;
  logic [15:0] in_tcdm_add_i = '0;
  logic [15:0] in_len_i = '0;
  logic        in_opc_i = 1'b0, in_sid_i = 1'b0, in_cid_i = 1'b0;
  logic        out_req_o;
  logic        out_gnt_i = 1'b0;
  logic [31:0] out_ext_add_o;
  logic [15:0] out_tcdm_add_o;
  logic [6:0]  out_len_o;
  logic        out_opc_o, out_sid_o, out_cid_o, out_last_o;
  logic        busy_o;
`ifdef MCHAN_SPLIT_STATS_EN
  logic [15:0] split_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [31:0] ext;
    logic [15:0] tcdm;
    logic [6:0]  len;
    logic        last;
  } sub_t;

  sub_t exp_q[$];

  always #5 clk = ~clk;

  mchan_trans_splitter dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .in_req_i      (in_req_i),
    .in_gnt_o      (in_gnt_o),
    .in_ext_add_i  (in_ext_add_i),
    .in_tcdm_add_i (in_tcdm_add_i),
    .in_len_i      (in_len_i),
    .in_opc_i      (in_opc_i),
    .in_sid_i      (in_sid_i),
    .in_cid_i      (in_cid_i),
    .out_req_o     (out_req_o),
    .out_gnt_i     (out_gnt_i),
    .out_ext_add_o (out_ext_add_o),
    .out_tcdm_add_o(out_tcdm_add_o),
    .out_len_o     (out_len_o),
    .out_opc_o     (out_opc_o),
    .out_sid_o     (out_sid_o),
    .out_cid_o     (out_cid_o),
    .out_last_o    (out_last_o),
`ifdef MCHAN_SPLIT_STATS_EN
    .split_cnt_o   (split_cnt_o),
`endif
    .busy_o        (busy_o)
  );

  // Reference: walk the byte range, cutting at every 128-byte boundary.
  task automatic build_model(input logic [31:0] ext, input logic [15:0] tcdm,
                             input logic [15:0] len);
    int unsigned rem;
    logic [31:0] e;
    logic [15:0] t;
    exp_q.delete();
    rem = int'(len) + 1;
    e = ext;
    t = tcdm;
    while (rem > 0) begin
      int unsigned room, c;
      sub_t s;
      room = 128 - (e % 128);
      c = (rem < room) ? rem : room;
      s.ext = e; s.tcdm = t; s.len = 7'(c - 1); s.last = (rem == c);
      exp_q.push_back(s);
      e = e + c;
      t = t + 16'(c);
      rem = rem - c;
    end
  endtask

  task automatic check_stats(input string name);
`ifdef MCHAN_SPLIT_STATS_EN
    checks++;
    if (split_cnt_o !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL %s split_cnt: got %0d want %0d", name, split_cnt_o, exp_cnt);
    end
`endif
  endtask

  task automatic wait_gnt(input string name);
    int n = 0;
    while (in_gnt_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL %s wait_gnt: in_gnt_o=%b after %0d cycles, want 1", name, in_gnt_o, n);
    end
  endtask

  task automatic check_sub(input string name, input int k, input sub_t e,
                           input logic [2:0] ids);
    checks++;
    if ({out_req_o, in_gnt_o, busy_o, out_ext_add_o, out_tcdm_add_o, out_len_o, out_last_o,
         out_opc_o, out_sid_o, out_cid_o} !==
        {1'b1, 1'b0, 1'b1, e.ext, e.tcdm, e.len, e.last, ids}) begin
      errors++;
      $display("FAIL %s sub%0d: got req=%b gnt=%b busy=%b ext=%h tcdm=%h len=%h last=%b ids=%b%b%b, want req=1 gnt=0 busy=1 ext=%h tcdm=%h len=%h last=%b ids=%b",
               name, k, out_req_o, in_gnt_o, busy_o, out_ext_add_o, out_tcdm_add_o, out_len_o,
               out_last_o, out_opc_o, out_sid_o, out_cid_o, e.ext, e.tcdm, e.len, e.last, ids);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({out_req_o, busy_o, in_gnt_o} !== 3'b001) begin
      errors++;
      $display("FAIL %s idle: got req=%b busy=%b gnt=%b, want req=0 busy=0 gnt=1",
               name, out_req_o, busy_o, in_gnt_o);
    end
  endtask

  // One full transaction with per-sub stalls in [min_st,max_st]; optional
  // garbage requests held on the input while the splitter is busy.
  task automatic run_trans(input string name, input logic [31:0] ext, input logic [15:0] tcdm,
                           input logic [15:0] len, input int min_st, input int max_st,
                           input bit hold_req);
    logic [2:0] ids;
    int nsub;
    ids = 3'($urandom);
    build_model(ext, tcdm, len);
    nsub = exp_q.size();
    wait_gnt(name);
    in_req_i = 1'b1;
    in_ext_add_i = ext; in_tcdm_add_i = tcdm; in_len_i = len;
    {in_opc_i, in_sid_i, in_cid_i} = ids;
    @(posedge clk); #1;
    in_req_i = hold_req;
    in_ext_add_i = $urandom; in_tcdm_add_i = 16'($urandom); in_len_i = 16'($urandom);
    {in_opc_i, in_sid_i, in_cid_i} = 3'($urandom);
    for (int k = 0; k < nsub; k++) begin
      int st;
      st = $urandom_range(max_st, min_st);
      for (int s = 0; s <= st; s++) begin
        out_gnt_i = (s == st);
        if (s == st && k == nsub - 1) in_req_i = 1'b0;
        @(negedge clk);
        check_sub(name, k, exp_q[k], ids);
        @(posedge clk); #1;
      end
      exp_cnt++;
    end
    out_gnt_i = 1'b0;
    in_req_i = 1'b0;
    @(negedge clk);
    check_idle(name);
    check_stats(name);
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_req_o, in_gnt_o, busy_o, out_ext_add_o, out_tcdm_add_o, out_len_o, out_last_o,
         out_opc_o, out_sid_o, out_cid_o} !== '0) begin
      errors++;
      $display("FAIL reset_state: got req=%b gnt=%b busy=%b ext=%h tcdm=%h len=%h last=%b, want all 0",
               out_req_o, in_gnt_o, busy_o, out_ext_add_o, out_tcdm_add_o, out_len_o, out_last_o);
    end
    rst_i = 1'b0;
    exp_cnt = 0;
    check_stats("reset");
    @(posedge clk); #1;
    @(negedge clk);
    check_idle("reset_release");
  endtask

  task automatic test_aligned_small;
    run_trans("aligned_small", 32'h0000_1000, 16'h0040, 16'h000F, 0, 0, 0);
  endtask

  task automatic test_boundary_cross;
    run_trans("boundary_cross", 32'h0000_1070, 16'h0200, 16'h001F, 0, 1, 0);
  endtask

  task automatic test_multi_burst;
    run_trans("multi_burst", 32'h0000_2000, 16'h0000, 16'h00FF, 0, 2, 1);
  endtask

  task automatic test_backpressure;
    run_trans("backpressure", 32'h0000_3040, 16'h1234, 16'h017F, 5, 5, 1);
  endtask

  task automatic test_addr_wrap;
    run_trans("addr_wrap", 32'hFFFF_FFF8, 16'hFFFC, 16'h000F, 0, 1, 0);
  endtask

  task automatic test_max_len;
    run_trans("max_len", 32'h0000_0005, 16'h0100, 16'hFFFF, 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    run_trans("b2b_a", 32'h0000_4010, 16'h0010, 16'h0008, 0, 0, 0);
    run_trans("b2b_b", 32'h0000_407F, 16'h0020, 16'h0001, 0, 0, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ext;
      logic [15:0] len;
      ext = $urandom;
      if (i % 4 == 0) ext = 32'hFFFF_FF00 | 32'($urandom_range(255, 0));
      len = 16'($urandom_range(600, 0));
      if (i % 5 == 0) len = 16'($urandom_range(7, 0));
      run_trans("random", ext, 16'($urandom), len, 0, 3, i[0]);
    end
  endtask

  task automatic test_reset_mid_split;
    logic [2:0] ids;
    ids = 3'b101;
    build_model(32'h0000_2000, 16'h0080, 16'h00FF);
    wait_gnt("rst_mid");
    in_req_i = 1'b1;
    in_ext_add_i = 32'h0000_2000; in_tcdm_add_i = 16'h0080; in_len_i = 16'h00FF;
    {in_opc_i, in_sid_i, in_cid_i} = ids;
    @(posedge clk); #1;
    in_req_i = 1'b0;
    out_gnt_i = 1'b1;
    @(negedge clk);
    check_sub("rst_mid", 0, exp_q[0], ids);
    @(posedge clk); #1;
    out_gnt_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({out_req_o, busy_o, in_gnt_o} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid in_reset: got req=%b busy=%b gnt=%b, want 000",
               out_req_o, busy_o, in_gnt_o);
    end
    exp_cnt = 0;
    check_stats("rst_mid");
    rst_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle("rst_mid_release");
    run_trans("after_rst", 32'h0000_5078, 16'h0300, 16'h0010, 0, 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_aligned_small();
    test_boundary_cross();
    test_multi_burst();
    test_backpressure();
    test_addr_wrap();
    test_back_to_back();
    test_max_len();
    test_random();
    test_reset_mid_split();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
